// File: rtl/led_oneshot_driver.sv
// One-shot LED blinker: a trigger pulse plays BLINK_COUNT lit phases separated by dark gaps.
// Define LED_RETRIGGER_EN to let a trigger during a running sequence restart it.
module led_oneshot_driver #(
  parameter int unsigned ON_CYCLES      = 13_500_000,
  parameter int unsigned OFF_CYCLES     = 13_500_000,
  parameter int unsigned BLINK_COUNT    = 3,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic iIntTrig,
  output logic oExtLed,
  output logic oBusy,
  output logic oDone
);

  localparam int unsigned MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned PH_W       = $clog2(MAX_CYCLES) + 1;
  localparam int unsigned BC_W       = $clog2(BLINK_COUNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [BC_W-1:0]   blink_q, blink_d;
  logic              done_d;
  logic              led_q, busy_q, done_q;
  logic              accept_c;
  logic              phase_end_c;

  // A trigger is honoured in IDLE always, and mid-sequence only when retrigger is built in.
  always_comb begin
`ifdef LED_RETRIGGER_EN
    accept_c = iIntTrig;
`else
    accept_c = iIntTrig && (state_q == ST_IDLE);
`endif
  end

  assign phase_end_c = (phase_q == '0);

  // Next-state: the phase counter counts down to zero, then the phase ends.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    blink_d = blink_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_ON: begin
        if (!phase_end_c) begin
          phase_d = phase_q - PH_W'(1);
        end else if (blink_q < BC_W'(BLINK_COUNT)) begin
          state_d = ST_OFF;
          phase_d = PH_W'(OFF_CYCLES - 1);
        end else begin
          state_d = ST_IDLE;
          phase_d = '0;
          blink_d = '0;
          done_d  = 1'b1;
        end
      end
      ST_OFF: begin
        if (!phase_end_c) begin
          phase_d = phase_q - PH_W'(1);
        end else begin
          state_d = ST_ON;
          phase_d = PH_W'(ON_CYCLES - 1);
          blink_d = blink_q + BC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        blink_d = '0;
      end
    endcase
    // A start overrides whatever the sequence would have done, including a pending done.
    if (accept_c) begin
      state_d = ST_ON;
      phase_d = PH_W'(ON_CYCLES - 1);
      blink_d = BC_W'(1);
      done_d  = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      blink_q <= '0;
      led_q   <= LED_ACTIVE_LOW;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      blink_q <= blink_d;
      led_q   <= (state_d == ST_ON) ^ LED_ACTIVE_LOW;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
    end
  end

  assign oExtLed = led_q;
  assign oBusy   = busy_q;
  assign oDone   = done_q;

endmodule

// File: tb/tb_led_oneshot_driver.sv
// Bench for led_oneshot_driver: hand-computed directed waveforms plus random triggers/resets
// checked every cycle against a sequence-position model.
module tb_led_oneshot_driver;

  localparam int unsigned ON_C   = 3;
  localparam int unsigned OFF_C  = 2;
  localparam int unsigned BC     = 2;
  localparam bit          ACT_LO = 1'b1;
  localparam int          PERIOD  = ON_C + OFF_C;
  localparam int          SEQ_LEN = BC * ON_C + (BC - 1) * OFF_C;
`ifdef LED_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic iIntTrig = 1'b0;
  logic oExtLed, oBusy, oDone;

  int total = 0;
  int bad   = 0;

  led_oneshot_driver #(
    .ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .BLINK_COUNT(BC), .LED_ACTIVE_LOW(ACT_LO)
  ) dut (
    .CLK(CLK), .RESET(RESET), .iIntTrig(iIntTrig),
    .oExtLed(oExtLed), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int cyc, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %b want %b (t=%0t)", nm, cyc, act, exp, $time);
    end
  endtask

  // Model: position within the current sequence (-1 = idle); the sequence is a fixed timeline.
  int pos = -1;
  bit done_m = 1'b0;
  bit mvalid = 1'b0;
  int mcyc = 0;

  always @(posedge CLK) begin
    mcyc++;
    if (RESET) begin
      pos = -1; done_m = 1'b0; mvalid = 1'b1;
    end else if (iIntTrig && (pos < 0 || RETRIG)) begin
      pos = 0; done_m = 1'b0;
    end else if (pos >= 0) begin
      if (pos + 1 < SEQ_LEN) begin
        pos++; done_m = 1'b0;
      end else begin
        pos = -1; done_m = 1'b1;
      end
    end else begin
      done_m = 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (mvalid) begin
      logic lit;
      lit = (pos >= 0) && ((pos % PERIOD) < ON_C);
      chk("model_led",  mcyc, oExtLed, lit ^ ACT_LO);
      chk("model_busy", mcyc, oBusy,   pos >= 0);
      chk("model_done", mcyc, oDone,   done_m);
    end
  end

  // Directed run: bit c of each mask is the input/expectation for cycle c (cycle 0 = now).
  task automatic run_seq(input string nm, input int ncyc,
                         input logic [31:0] trig_m, input logic [31:0] rst_m,
                         input logic [31:0] led_m, input logic [31:0] busy_m,
                         input logic [31:0] done_m_in);
    iIntTrig = trig_m[0];
    RESET    = rst_m[0];
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge CLK);
      #1;
      iIntTrig = trig_m[c];
      RESET    = rst_m[c];
      chk({nm, "_led"},  c, oExtLed, led_m[c]);
      chk({nm, "_busy"}, c, oBusy,   busy_m[c]);
      chk({nm, "_done"}, c, oDone,   done_m_in[c]);
    end
    iIntTrig = 1'b0;
    RESET    = 1'b0;
  endtask

  initial begin
    @(posedge CLK);
    #1;
    // Reset held two cycles with trigger high: idle and dark from the first edge on.
    run_seq("reset", 4, 32'h3, 32'h3, 32'h1E, 32'h0, 32'h0);

    run_seq("basic", 12, 32'h1, 32'h0, 32'h1E30, 32'h1FE, 32'h200);

    run_seq("b2b", 20, 32'h201, 32'h0, 32'h1C6230, 32'h3FDFE, 32'h40200);

`ifdef LED_RETRIGGER_EN
    run_seq("busytrig", 15, 32'h11, 32'h0, 32'hE310, 32'h1FFE, 32'h2000);
`else
    run_seq("busytrig", 15, 32'h11, 32'h0, 32'hFE30, 32'h1FE, 32'h200);
`endif

    run_seq("midreset", 20, 32'h1, 32'h20, 32'h1FFFF0, 32'h3E, 32'h0);

    // Random triggers (incl. multi-cycle) and occasional resets, checked by the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK);
      #1;
      iIntTrig = ($urandom_range(0, 7) == 0);
      RESET    = ($urandom_range(0, 149) == 0);
    end
    iIntTrig = 1'b0;
    RESET    = 1'b0;
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
